// File: rtl/iomem_gpio_pkg.sv
// iomem_gpio_pkg: shared definitions for the iomem GPIO peripheral.
// Provides the register index map, the register-index width and the
// byte-lane merge helpers used to apply iomem write strobes.
package iomem_gpio_pkg;

    localparam int unsigned REG_IDX_W = 3;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_OUT      = 3'd0;
    localparam reg_idx_t REG_OE       = 3'd1;
    localparam reg_idx_t REG_IN       = 3'd2;
    localparam reg_idx_t REG_IRQ_EN   = 3'd3;
    localparam reg_idx_t REG_EDGE_POL = 3'd4;
    localparam reg_idx_t REG_STATUS   = 3'd5;

    // Expand the 4-bit byte strobe into a 32-bit bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] wstrb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{wstrb[i]}};
        end
        return m;
    endfunction

    // Replace the strobed byte lanes of old_val with the matching lanes of wdata.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
        logic [31:0] m;
        m = strb_mask(wstrb);
        return (old_val & ~m) | (wdata & m);
    endfunction

endpackage

// File: rtl/iomem_gpio_if.sv
// iomem_gpio_if: PicoSoC iomem bus bundle.
//   iomem_valid  request from master
//   iomem_ready  one-cycle response pulse from slave
//   iomem_wstrb  byte write strobes (0 = read)
//   iomem_addr   byte address
//   iomem_wdata  write data
//   iomem_rdata  read data, valid while iomem_ready = 1
interface iomem_gpio_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: synchroniser and edge detector for asynchronous pad inputs.
//   clk, resetn  clock and synchronous active-low reset
//   pins         asynchronous inputs
//   pol          per-bit edge polarity (1 = rising, 0 = falling)
//   sync         synchronised inputs (last stage of the chain)
//   edges        combinational pulse: sync changed and now equals pol
module gpio_sync_edge #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] pins,
    input  logic [WIDTH-1:0] pol,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] edges
);

    logic [WIDTH-1:0] chain_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            chain_q[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
            prev_q <= chain_q[SYNC_STAGES-1];
        end
    end

    assign sync  = chain_q[SYNC_STAGES-1];
    assign edges = (sync ^ prev_q) & ~(sync ^ pol);

endmodule

// File: rtl/iomem_gpio.sv
// iomem_gpio: parametrised GPIO slave on the PicoSoC iomem bus.
//   clk, resetn  clock and synchronous active-low reset
//   bus          iomem slave port; decodes iomem_addr[31:24] == BASE_ADDR
//   gpio_in      asynchronous pad inputs
//   gpio_out     output data register
//   gpio_oe      output enable register (1 = drive)
//   irq          registered level interrupt, |(IRQ_STATUS & IRQ_EN)
module iomem_gpio
    import iomem_gpio_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter logic [7:0]  BASE_ADDR   = 8'h03,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    iomem_gpio_if.slave      bus,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam int unsigned     ARM_W   = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] out_q, out_d, oe_q, oe_d, en_q, en_d, pol_q, pol_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] sync_val, edges, set_bits;
    logic [ARM_W-1:0] arm_q, arm_d;
    logic             ready_q, irq_q, irq_d;
    logic [31:0]      rdata_q, rdata_d, rd_val, merged, clr;
    logic             hit, accept, wr, armed;
    reg_idx_t         idx;
    logic             unused_addr;

    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .resetn (resetn),
        .pins   (gpio_in),
        .pol    (pol_q),
        .sync   (sync_val),
        .edges  (edges)
    );

    assign hit         = bus.iomem_addr[31:24] == BASE_ADDR;
    assign accept      = bus.iomem_valid && !ready_q && hit;
    assign wr          = accept && (bus.iomem_wstrb != 4'b0000);
    assign idx         = bus.iomem_addr[4:2];
    assign unused_addr = ^{bus.iomem_addr[23:5], bus.iomem_addr[1:0]};

    // Edges are masked until the sync chain and prev register hold real pin
    // values, so reset zeros never look like transitions.
    assign armed    = arm_q == ARM_MAX;
    assign arm_d    = armed ? arm_q : arm_q + 1'b1;
    assign set_bits = armed ? edges : '0;

    // Current (pre-write) value of the addressed register, zero-extended.
    always_comb begin
        rd_val = '0;
        case (idx)
            REG_OUT:      rd_val[WIDTH-1:0] = out_q;
            REG_OE:       rd_val[WIDTH-1:0] = oe_q;
            REG_IN:       rd_val[WIDTH-1:0] = sync_val;
            REG_IRQ_EN:   rd_val[WIDTH-1:0] = en_q;
            REG_EDGE_POL: rd_val[WIDTH-1:0] = pol_q;
            REG_STATUS:   rd_val[WIDTH-1:0] = status_q;
            default:      rd_val = '0;
        endcase
    end

    assign merged = byte_merge(rd_val, bus.iomem_wdata, bus.iomem_wstrb);
    assign clr    = bus.iomem_wdata & strb_mask(bus.iomem_wstrb);

    always_comb begin
        out_d    = out_q;
        oe_d     = oe_q;
        en_d     = en_q;
        pol_d    = pol_q;
        // A newly detected edge wins over a simultaneous W1C of the same bit.
        status_d = status_q | set_bits;
        if (wr) begin
            case (idx)
                REG_OUT:      out_d    = merged[WIDTH-1:0];
                REG_OE:       oe_d     = merged[WIDTH-1:0];
                REG_IRQ_EN:   en_d     = merged[WIDTH-1:0];
                REG_EDGE_POL: pol_d    = merged[WIDTH-1:0];
                REG_STATUS:   status_d = (status_q & ~clr[WIDTH-1:0]) | set_bits;
                default:      ;
            endcase
        end
        rdata_d = accept ? rd_val : rdata_q;
        irq_d   = |(status_q & en_q);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_q    <= '0;
            oe_q     <= '0;
            en_q     <= '0;
            pol_q    <= '0;
            status_q <= '0;
            arm_q    <= '0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            out_q    <= out_d;
            oe_q     <= oe_d;
            en_q     <= en_d;
            pol_q    <= pol_d;
            status_q <= status_d;
            arm_q    <= arm_d;
            ready_q  <= accept;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign gpio_out        = out_q;
    assign gpio_oe         = oe_q;
    assign irq             = irq_q;

endmodule
